spi_tx_master: RTL and testbench
================================

Name: spi_tx_master

Overview:
- SPI initiator (transmit side). Takes bytes from core logic over a valid/ready handshake and serialises them onto CS/SCLK/DO.
- Line format matches the team's SPI receive buffer (SpiBuffer):
  - CS active-low, high when idle
  - SCLK idles low
  - DO changes while SCLK is low and is sampled on the SCLK rising edge
  - LSB first, 8 bits per byte
- Multi-byte frames: CS stays low from the first byte until the byte marked InLast has been sent.

Parameters:
- CLK_DIV, 4: system CLK cycles per SCLK half-period; legal range >= 1.
- CS_GAP, 2: minimum CS-high time between frames, in half-periods (CS_GAP*CLK_DIV cycles); legal range >= 1.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- InData  in  8  byte to send.
- InLast  in  1  qualifies InData: this byte ends the frame.
- InValid  in  1  InData/InLast valid.
- InReady  out  1  block can accept a byte this cycle; transfer occurs when InValid && InReady.
- SCLK  out  1  serial clock, idle low.
- CS  out  1  chip select, active-low.
- DO  out  1  serial data out.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when a frame fully completes (end of GAP).

Behaviour:
- Clocking: one clock domain. Reset is asynchronous, active-high. All outputs are registered except InReady, which is a decode of state.
- Reset values: CS=1, SCLK=0, DO=0, Busy=0, Done=0, state=IDLE, all counters and the shift register 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). The frame is abandoned, no Done is pulsed, and any byte in flight is lost.
- Half-period timer: divider counter counts CLK_DIV cycles per state below (GAP uses CS_GAP*CLK_DIV). Counter width = $clog2(CS_GAP*CLK_DIV+1).
- IDLE
  - Outputs: CS=1, SCLK=0, InReady=1.
  - On transfer: load shift register from InData, latch InLast, clear bit count, set DO=InData[0], move to LEAD.
  - CS falls on the next CLK edge, i.e. one cycle after the transfer.
- LEAD: CS=0, SCLK=0, for CLK_DIV cycles -> HIGH.
- HIGH
  - SCLK=1 for CLK_DIV cycles; DO stable throughout.
  - At the end: if bit count < 7, increment it, shift, present the next bit on DO, go to LOW.
  - After bit 7: go to TRAIL if the latched last flag is set, otherwise go to NEXT.
- LOW: SCLK=0 for CLK_DIV cycles -> HIGH.
- NEXT
  - Outputs: CS=0, SCLK=0, InReady=1.
  - Waits indefinitely (stall) for a transfer. CS is held low and SCLK does not toggle.
  - On transfer: load the byte, DO=InData[0], clear bit count, latch InLast, go to LOW for a full setup half-period.
- TRAIL: CS=0, SCLK=0, for CLK_DIV cycles -> GAP.
- GAP: CS=1, SCLK=0, DO=0, for CS_GAP*CLK_DIV cycles. Done=1 on the cycle the state returns to IDLE.
- InReady is 0 in LEAD, HIGH, LOW, TRAIL and GAP. A byte presented while InReady=0 is held by the producer, not dropped.
- Timing: a single-byte frame holds CS low for exactly 17*CLK_DIV cycles (LEAD + 8 HIGH + 7 LOW + TRAIL). Back-to-back bytes with no stall insert exactly one extra half-period (the LOW after NEXT) plus the single NEXT cycle.
- Exactly 8 rising SCLK edges per byte. No SCLK edge ever occurs while CS=1.
- InLast is sampled only on transfer. Deasserting it later has no effect.

Optional Feature:
- Macro: SPI_TX_MSB_FIRST_EN.
- Defined: bits are shifted MSB first (DO=InData[7] at load, then left shifts). All timing is unchanged.
- Undefined (default): LSB first, as specified above. This is required for compatibility with SpiBuffer.

Test Plan:
- Single byte, CLK_DIV=2:
  - Stimulus: InData=122, InLast=1.
  - Required response: DO sampled at the 8 SCLK rises = 0,1,0,1,1,1,1,0. CS low for 34 cycles. Done pulses once. Busy falls with the return to IDLE.
- Two-byte frame, producer always valid:
  - Stimulus: bytes 122 then 128 (InLast on 128).
  - Required response: CS low continuously. 16 SCLK rises. Second byte sampled as 0,0,0,0,0,0,0,1.
- Stall:
  - Stimulus: byte 12 (InLast=0), then InValid withheld for 20 cycles, then byte 64 with InLast=1.
  - Required response: SCLK stays low and CS stays low throughout the stall. Frame then resumes and completes with one Done.
- Loopback to SpiBuffer (DI=DO, CS=CS, CLK=SCLK):
  - Stimulus: frames of 122,128 and 12,64.
  - Required response: Buffer shows each byte in order and Changed fires per byte.
- Reset mid-frame:
  - Stimulus: assert RST during the 4th HIGH.
  - Required response: CS=1, SCLK=0, DO=0 within the same cycle (asynchronously). No Done. The next frame after release is correct.
- CLK_DIV=1, CS_GAP=1:
  - Stimulus: two consecutive single-byte frames.
  - Required response: CS low 17 cycles per frame. CS high at least 1 cycle between frames. InReady=0 while in GAP.
- Macro build: with SPI_TX_MSB_FIRST_EN defined, byte 122 is emitted as 0,1,1,1,1,0,1,0.

Source files
------------

// File: rtl/spi_tx_master.sv
// SPI transmit initiator: bytes from a valid/ready stream go out on CS/SCLK/DO, LSB first.
// Define SPI_TX_MSB_FIRST_EN to shift MSB first instead (timing unchanged).
module spi_tx_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] InData,
    input  logic       InLast,
    input  logic       InValid,
    output logic       InReady,
    output logic       SCLK,
    output logic       CS,
    output logic       DO,
    output logic       Busy,
    output logic       Done
);
    localparam int GAP_CYC = CS_GAP * CLK_DIV;
    localparam int CW      = $clog2(GAP_CYC + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_HIGH, S_LOW, S_NEXT, S_TRAIL, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    sh_q, sh_d;   // bits still to send; the current bit lives in do_q
    logic          last_q, last_d;
    logic          cs_q, cs_d, sclk_q, sclk_d, do_q, do_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          xfer, tick;

    assign InReady = (state_q == S_IDLE) || (state_q == S_NEXT);
    assign xfer    = InValid && InReady;
    assign tick    = (cnt_q == ((state_q == S_GAP) ? GAP_LAST : HALF_LAST));

    assign SCLK = sclk_q;
    assign CS   = cs_q;
    assign DO   = do_q;
    assign Busy = busy_q;
    assign Done = done_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            do_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            do_q    <= do_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        last_d  = last_q;
        do_d    = do_q;
        done_d  = 1'b0;
        if (tick) cnt_d = '0;

        case (state_q)
            S_IDLE, S_NEXT: begin
                cnt_d = '0;
                if (xfer) begin
                    last_d = InLast;
                    bit_d  = '0;
`ifdef SPI_TX_MSB_FIRST_EN
                    sh_d   = InData[6:0];
                    do_d   = InData[7];
`else
                    sh_d   = InData[7:1];
                    do_d   = InData[0];
`endif
                    // A byte taken mid-frame gets a full LOW half-period of setup
                    state_d = (state_q == S_IDLE) ? S_LEAD : S_LOW;
                end
            end
            S_LEAD:  if (tick) state_d = S_HIGH;
            S_LOW:   if (tick) state_d = S_HIGH;
            S_HIGH: begin
                if (tick) begin
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
`ifdef SPI_TX_MSB_FIRST_EN
                        do_d  = sh_q[6];
                        sh_d  = {sh_q[5:0], 1'b0};
`else
                        do_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[6:1]};
`endif
                        state_d = S_LOW;
                    end else begin
                        state_d = last_q ? S_TRAIL : S_NEXT;
                    end
                end
            end
            S_TRAIL: begin
                if (tick) begin
                    state_d = S_GAP;
                    do_d    = 1'b0;
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cs_d   = (state_d == S_IDLE) || (state_d == S_GAP);
        sclk_d = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
    end
endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: two instances (CLK_DIV=2/CS_GAP=2 and CLK_DIV=1/CS_GAP=1),
// bit/byte scoreboards fed at each handshake and drained at each SCLK rise.
module tb_spi_tx_master;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] InData0 = '0, InData1 = '0;
    logic       InLast0 = 1'b0, InLast1 = 1'b0, InValid0 = 1'b0, InValid1 = 1'b0;
    logic       InReady0, SCLK0, CS0, DO0, Busy0, Done0;
    logic       InReady1, SCLK1, CS1, DO1, Busy1, Done1;

    int pass_cnt = 0;
    int total_cnt = 0;

    spi_tx_master #(.CLK_DIV(2), .CS_GAP(2)) u_dut0 (
        .CLK(CLK), .RST(RST), .InData(InData0), .InLast(InLast0), .InValid(InValid0),
        .InReady(InReady0), .SCLK(SCLK0), .CS(CS0), .DO(DO0), .Busy(Busy0), .Done(Done0)
    );
    spi_tx_master #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .InData(InData1), .InLast(InLast1), .InValid(InValid1),
        .InReady(InReady1), .SCLK(SCLK1), .CS(CS1), .DO(DO1), .Busy(Busy1), .Done(Done1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // scoreboards
    logic       q0[$], q1[$];
    logic [7:0] bq0[$];
    int         cl1[$], hr1[$];

    task automatic push_bits(input logic [7:0] d, input int which);
        for (int i = 0; i < 8; i++) begin
`ifdef SPI_TX_MSB_FIRST_EN
            if (which == 0) q0.push_back(d[7-i]); else q1.push_back(d[7-i]);
`else
            if (which == 0) q0.push_back(d[i]); else q1.push_back(d[i]);
`endif
        end
        if (which == 0) bq0.push_back(d);
    endtask

    // DUT0 monitor: SCLK-rise sampling, SpiBuffer-style byte reassembly, CS-low length, Done count
    logic       sp0 = 1'b0;
    logic [7:0] acc0 = '0;
    int         nb0 = 0, rises0 = 0, done0 = 0, cs_run0 = 0, cs_len0 = 0;
    always @(negedge CLK) begin
        if (RST) begin
            sp0 = 1'b0; nb0 = 0; acc0 = '0; cs_run0 = 0;
        end else begin
            if (SCLK0 && !sp0) begin
                rises0++;
                chk("cs_low_at_rise0", int'(CS0), 0);
                chk("bitq0_nonempty", int'(q0.size() != 0), 1);
                if (q0.size() != 0) chk("bit0", int'(DO0), int'(q0.pop_front()));
`ifdef SPI_TX_MSB_FIRST_EN
                acc0 = {acc0[6:0], DO0};
`else
                acc0 = {DO0, acc0[7:1]};
`endif
                nb0++;
                if (nb0 == 8) begin
                    nb0 = 0;
                    chk("byteq0_nonempty", int'(bq0.size() != 0), 1);
                    if (bq0.size() != 0) chk("byte0", int'(acc0), int'(bq0.pop_front()));
                end
            end
            sp0 = SCLK0;
            if (!CS0) cs_run0++;
            else if (cs_run0 != 0) begin cs_len0 = cs_run0; cs_run0 = 0; end
            if (Done0) done0++;
        end
    end

    // DUT1 monitor: bits, CS low/high run lengths, GAP behaviour
    logic sp1 = 1'b0;
    int   rises1 = 0, done1 = 0, cs_run1 = 0, hi_run1 = 0, gap_cyc1 = 0, gap_rdy1 = 0;
    always @(negedge CLK) begin
        if (RST) begin
            sp1 = 1'b0; cs_run1 = 0; hi_run1 = 0;
        end else begin
            if (SCLK1 && !sp1) begin
                rises1++;
                chk("cs_low_at_rise1", int'(CS1), 0);
                chk("bitq1_nonempty", int'(q1.size() != 0), 1);
                if (q1.size() != 0) chk("bit1", int'(DO1), int'(q1.pop_front()));
            end
            sp1 = SCLK1;
            if (!CS1) begin
                if (hi_run1 != 0) begin hr1.push_back(hi_run1); hi_run1 = 0; end
                cs_run1++;
            end else begin
                if (cs_run1 != 0) begin cl1.push_back(cs_run1); cs_run1 = 0; end
                hi_run1++;
            end
            if (CS1 && Busy1) begin
                gap_cyc1++;
                if (InReady1) gap_rdy1++;
            end
            if (Done1) done1++;
        end
    end

    task automatic tick();
        @(negedge CLK); #1;
    endtask

    task automatic send0(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        tick();
        InData0 = d; InLast0 = last; InValid0 = 1'b1;
        while (!InReady0 && n < 2000) begin tick(); n++; end
        chk("ready0_timeout", int'(n < 2000), 1);
        push_bits(d, 0);
        @(posedge CLK); #1;
        InValid0 = 1'b0; InLast0 = 1'b0; InData0 = '0;
    endtask

    task automatic send1(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        tick();
        InData1 = d; InLast1 = last; InValid1 = 1'b1;
        while (!InReady1 && n < 2000) begin tick(); n++; end
        chk("ready1_timeout", int'(n < 2000), 1);
        push_bits(d, 1);
        @(posedge CLK); #1;
        InValid1 = 1'b0; InLast1 = 1'b0; InData1 = '0;
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        tick();
        while (Busy0 && n < 3000) begin tick(); n++; end
        chk("idle0_timeout", int'(n < 3000), 1);
        chk("done_with_idle0", int'(Done0), 1);
        tick();
        chk("done_pulse_width0", int'(Done0), 0);
    endtask

    initial begin
        int d0, r0, n, bad;
        repeat (3) tick();
        chk("reset_held0", int'({CS0, SCLK0, DO0, Busy0, Done0, InReady0}), int'(6'b100001));
        RST = 1'b0;
        tick();
        chk("reset_state0", int'({CS0, SCLK0, DO0, Busy0, Done0, InReady0}), int'(6'b100001));
        chk("reset_state1", int'({CS1, SCLK1, DO1, Busy1, Done1, InReady1}), int'(6'b100001));

        // single byte
        d0 = done0; r0 = rises0;
        send0(8'd122, 1'b1);
        chk("ready_low_in_lead0", int'(InReady0), 0);
        wait_idle0();
        chk("single_cs_len0", cs_len0, 34);
        chk("single_rises0", rises0 - r0, 8);
        chk("single_done0", done0 - d0, 1);

        // two-byte frame, producer always valid
        d0 = done0; r0 = rises0;
        send0(8'd122, 1'b0);
        send0(8'd128, 1'b1);
        wait_idle0();
        chk("pair_cs_len0", cs_len0, 67);
        chk("pair_rises0", rises0 - r0, 16);
        chk("pair_done0", done0 - d0, 1);

        // stall in NEXT
        d0 = done0;
        send0(8'd12, 1'b0);
        n = 0;
        while (!InReady0 && n < 2000) begin tick(); n++; end
        chk("next_wait_timeout0", int'(n < 2000), 1);
        r0 = rises0; bad = 0;
        repeat (20) begin
            tick();
            if (SCLK0 || CS0) bad++;
        end
        chk("stall_lines0", bad, 0);
        chk("stall_no_rise0", rises0 - r0, 0);
        chk("stall_ready0", int'(InReady0), 1);
        send0(8'd64, 1'b1);
        wait_idle0();
        chk("stall_done0", done0 - d0, 1);
        chk("bitq0_drained", q0.size(), 0);
        chk("byteq0_drained", bq0.size(), 0);

        // reset during the 4th HIGH
        d0 = done0; r0 = rises0;
        send0(8'd122, 1'b1);
        n = 0;
        while (rises0 - r0 < 4 && n < 2000) begin tick(); n++; end
        chk("fourth_rise_timeout0", int'(n < 2000), 1);
        chk("in_high_before_rst0", int'({CS0, SCLK0, DO0}), int'(3'b011));
        #1 RST = 1'b1;
        #1 chk("rst_async0", int'({CS0, SCLK0, DO0, Busy0, Done0}), int'(5'b10000));
        q0.delete();
        bq0.delete();
        repeat (3) tick();
        RST = 1'b0;
        repeat (4) tick();
        chk("no_done_after_rst0", done0 - d0, 0);
        r0 = rises0;
        send0(8'd128, 1'b1);
        wait_idle0();
        chk("post_rst_cs_len0", cs_len0, 34);
        chk("post_rst_rises0", rises0 - r0, 8);
        chk("post_rst_done0", done0 - d0, 1);
        chk("post_rst_byteq0", bq0.size(), 0);

        // CLK_DIV=1, CS_GAP=1: two single-byte frames
        cl1.delete(); hr1.delete();
        d0 = done1;
        send1(8'd122, 1'b1);
        send1(8'd128, 1'b1);
        n = 0;
        tick();
        while ((Busy1 || cl1.size() < 2) && n < 2000) begin tick(); n++; end
        chk("idle1_timeout", int'(n < 2000), 1);
        tick();
        chk("frames1", cl1.size(), 2);
        if (cl1.size() == 2) begin
            chk("cs_len1_a", cl1[0], 17);
            chk("cs_len1_b", cl1[1], 17);
        end
        chk("cs_high_runs1", hr1.size(), 2);
        if (hr1.size() == 2) chk("cs_gap1_ge1", int'(hr1[1] >= 1), 1);
        chk("gap_cycles1", gap_cyc1, 2);
        chk("gap_ready1", gap_rdy1, 0);
        chk("done1", done1 - d0, 2);
        chk("rises1", rises1, 16);
        chk("bitq1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
